regfile_wr_arbiter: RTL
=======================

Name: regfile_wr_arbiter

Overview:
- Single-owner controller for the 32x32 register file's only write port; its outputs drive the file's wren/wraddr/wrdata.
- Merges three write sources: the pipeline WB stage (never stalls), the multi-cycle mul/div unit (valid/ready) and the debug port (valid/ready).
- Tracks registers whose result is still owed by the mul/div unit in a pending scoreboard; decode uses the stall output to hold dependent instructions.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a debug request may wait before it outranks mul/div.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  WB-stage write this cycle; always accepted.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- md_valid  in  1  mul/div result available.
- md_ready  out  1  mul/div result accepted this cycle.
- md_addr  in  5  mul/div destination register.
- md_data  in  32  mul/div result.
- dbg_valid  in  1  debug write request.
- dbg_ready  out  1  debug write accepted this cycle.
- dbg_addr  in  5  debug destination register.
- dbg_data  in  32  debug write data.
- iss_set  in  1  mul/div op issued; mark iss_addr pending.
- iss_addr  in  5  destination of the issued mul/div op.
- rs_addr  in  5  decode source register 1.
- rt_addr  in  5  decode source register 2.
- stall  out  1  decode hazard on a pending register.
- rf_wren  out  1  to register file wren.
- rf_wraddr  out  5  to register file wraddr.
- rf_wrdata  out  32  to register file wrdata.
- err_waw  out  1  sticky: WB wrote a register that was still pending.

Behaviour:
- Reset, asynchronous: rf_wren=0, rf_wraddr=0, rf_wrdata=0, pending=0, starve_cnt=0, err_waw=0.
- Grant priority, evaluated combinationally each cycle:
  - wb_valid wins unconditionally.
  - Otherwise, if dbg_valid && starve_cnt>=STARVE_LIMIT, debug wins.
  - Otherwise md_valid, then dbg_valid.
- md_ready and dbg_ready are combinational grant signals. A source's transfer happens on a posedge where its valid&&ready is high. Valid and its addr/data must stay stable until ready.
- Write latency: grant in cycle N. At posedge ending N, rf_wren/rf_wraddr/rf_wrdata register the winner. The register file commits at the negedge inside cycle N+1.
- With no grant, rf_wren=0 and rf_wraddr/rf_wrdata hold their values.
- Writes to address 0 complete the handshake but register rf_wren=0.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each posedge where dbg_valid && !dbg_ready.
  - Clears on a debug grant or when dbg_valid=0.
- Scoreboard (32-bit pending vector):
  - iss_set with iss_addr!=0 sets pending[iss_addr].
  - A mul/div grant clears pending[md_addr].
  - Same-edge set and clear of the same index: set wins, because a new op re-owns the register.
  - pending[0] is always 0.
- stall = (rs_addr!=0 && pending[rs_addr]) || (rt_addr!=0 && pending[rt_addr]). It is combinational from registered state, so a pending bit set at edge E stalls from cycle E+1.
- A clear at edge E drops stall from E+1. Decode then reads the value committed at the negedge of E+1.
- err_waw sets at the posedge where wb_valid && wb_addr!=0 && pending[wb_addr]. It clears only on reset.
- Reset mid-handshake: in-flight grants are discarded and pending is cleared. Sources must re-present after reset.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
  - Source-ID encoding: SRC_NONE=0, SRC_WB=1, SRC_MD=2, SRC_DBG=3.
- One natural sub-module: regfile_scoreboard. It owns the pending vector, the set/clear rules, the stall lookup and the err_waw detection.
- Arbitration, the starvation counter and the output registers stay in the top module.

Test Plan:
1. Reset while rf_wren=1 and pending=32'h0000_0010 -> all outputs 0 and pending=0 immediately, without waiting for a clock edge.
2. wb_valid=1 (addr 5, 32'hAAAA_0001), md_valid=1 (addr 6), dbg_valid=1 on the same cycle -> md_ready=0, dbg_ready=0.
   - Next cycle: rf_wraddr=5, rf_wrdata=32'hAAAA_0001, rf_wren=1.
   - With wb_valid=0 the cycle after, md is granted, then dbg.
3. md_valid held high continuously, dbg_valid=1 (addr 9, 32'h1234) -> dbg_ready=0 for 4 cycles.
   - dbg_ready=1 on the 5th cycle; rf_wraddr=9 one cycle later; the counter returns to 0.
4. iss_set addr 8, then rs_addr=8 -> stall=1 from the next cycle.
   - md grant addr 8 data 32'h00C0_FFEE -> stall=0 the cycle after the grant edge; rf_wrdata=32'h00C0_FFEE.
5. iss_set addr 3 on the same edge as an md grant for addr 3 -> pending[3] stays 1 and stall persists for rt_addr=3.
   - iss_set addr 0 -> no stall for rs_addr=0.
6. pending[4]=1, then wb_valid addr 4 -> err_waw=1 and stays 1.
   - dbg write to addr 0 -> dbg_ready=1, rf_wren stays 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter and its scoreboard.
package regfile_wr_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Identifies which source owns the write port in a given cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_MD   = 2'd2,
        SRC_DBG  = 2'd3
    } src_e;

    // True when a non-zero register is still owed a mul/div result.
    function automatic logic is_pending(input logic [NUM_REGS-1:0] vec,
                                        input logic [REG_ADDR_W-1:0] addr);
        return (addr != {REG_ADDR_W{1'b0}}) && vec[addr];
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-result scoreboard: tracks registers owed by the mul/div unit,
// drives the decode stall and flags WB writes that overtake a pending result.
module regfile_scoreboard
    import regfile_wr_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_set,
    input  logic [REG_ADDR_W-1:0] iss_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  stall,
    output logic                  err_waw
);

    logic [NUM_REGS-1:0] pending_r;
    logic [NUM_REGS-1:0] pending_nxt_s;
    logic                err_waw_r;
    logic                waw_hit_s;

    // Next pending vector: clear first, then set, so a new issue re-owns the register.
    always_comb begin
        pending_nxt_s = pending_r;
        if (clr_en) begin
            pending_nxt_s[clr_addr] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (iss_set && (iss_addr != {REG_ADDR_W{1'b0}})) begin
            pending_nxt_s[iss_addr] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        pending_nxt_s[0] = 1'b0;
    end

    // Hazard detection on decode sources and on the WB destination.
    always_comb begin
        stall     = is_pending(pending_r, rs_addr) || is_pending(pending_r, rt_addr);
        waw_hit_s = wb_valid && is_pending(pending_r, wb_addr);
    end

    // Pending vector and sticky WAW error register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_r <= {NUM_REGS{1'b0}};
            err_waw_r <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            if (waw_hit_s) begin
                err_waw_r <= 1'b1;
            end
        end
    end

    assign err_waw = err_waw_r;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single owner of the register file write port: arbitrates WB, mul/div and
// debug writes, protects debug from starvation and registers the winner.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    input  logic        iss_set,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        stall,
    output logic        rf_wren,
    output logic [4:0]  rf_wraddr,
    output logic [31:0] rf_wrdata,
    output logic        err_waw
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    src_e                  grant_s;
    logic                  md_fire_s;
    logic [CNT_W-1:0]      starve_cnt_r;
    logic                  rf_wren_r;
    logic [REG_ADDR_W-1:0] rf_wraddr_r;
    logic [REG_DATA_W-1:0] rf_wrdata_r;

    // Fixed-priority grant with debug promoted above mul/div once starved.
    always_comb begin
        grant_s = SRC_NONE;
        if (wb_valid) begin
            grant_s = SRC_WB;
        end else if (dbg_valid && (starve_cnt_r >= LIMIT_C)) begin
            grant_s = SRC_DBG;
        end else if (md_valid) begin
            grant_s = SRC_MD;
        end else if (dbg_valid) begin
            grant_s = SRC_DBG;
        end else begin
            grant_s = SRC_NONE;
        end
    end

    assign md_ready  = (grant_s == SRC_MD);
    assign dbg_ready = (grant_s == SRC_DBG);
    assign md_fire_s = md_valid && md_ready;

    // Debug starvation counter: counts waiting cycles, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (dbg_valid && !dbg_ready) begin
            if (starve_cnt_r < LIMIT_C) begin
                starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Write-port output registers; address 0 completes the handshake without a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wren_r   <= 1'b0;
            rf_wraddr_r <= {REG_ADDR_W{1'b0}};
            rf_wrdata_r <= {REG_DATA_W{1'b0}};
        end else begin
            case (grant_s)
                SRC_WB: begin
                    rf_wren_r   <= (wb_addr != {REG_ADDR_W{1'b0}});
                    rf_wraddr_r <= wb_addr;
                    rf_wrdata_r <= wb_data;
                end
                SRC_MD: begin
                    rf_wren_r   <= (md_addr != {REG_ADDR_W{1'b0}});
                    rf_wraddr_r <= md_addr;
                    rf_wrdata_r <= md_data;
                end
                SRC_DBG: begin
                    rf_wren_r   <= (dbg_addr != {REG_ADDR_W{1'b0}});
                    rf_wraddr_r <= dbg_addr;
                    rf_wrdata_r <= dbg_data;
                end
                default: begin
                    rf_wren_r <= 1'b0;
                end
            endcase
        end
    end

    assign rf_wren   = rf_wren_r;
    assign rf_wraddr = rf_wraddr_r;
    assign rf_wrdata = rf_wrdata_r;

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_set  (iss_set),
        .iss_addr (iss_addr),
        .clr_en   (md_fire_s),
        .clr_addr (md_addr),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .stall    (stall),
        .err_waw  (err_waw)
    );

endmodule
